// File: rtl/car_alarm_chime.sv
// Car alarm chime: debounces a raw warning level, beeps on/off, escalates to a
// continuous tone after a number of beep cycles, and supports an acknowledge snooze.
module car_alarm_chime #(
   parameter int unsigned DEB_TICKS    = 4,
   parameter int unsigned ON_TICKS     = 8,
   parameter int unsigned OFF_TICKS    = 8,
   parameter int unsigned ESC_CYCLES   = 3,
   parameter int unsigned SNOOZE_TICKS = 64
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Alarm,
   input  logic       Tick,
   input  logic       Ack,
   output logic       Chime,
   output logic       Lamp,
   output logic       Escalated,
   output logic [2:0] State
);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StQualify  = 3'd1;
   localparam logic [2:0] StBeepOn   = 3'd2;
   localparam logic [2:0] StBeepOff  = 3'd3;
   localparam logic [2:0] StEscalate = 3'd4;
   localparam logic [2:0] StSnooze   = 3'd5;

   localparam logic [7:0] DebLast = 8'(DEB_TICKS - 1);
   localparam logic [7:0] OnLast  = 8'(ON_TICKS - 1);
   localparam logic [7:0] OffLast = 8'(OFF_TICKS - 1);
   localparam logic [7:0] SnzLast = 8'(SNOOZE_TICKS - 1);
   localparam logic [3:0] EscCnt  = 4'(ESC_CYCLES);

   logic       alarm_meta_q, alarm_s_q;
   logic [2:0] state_q, state_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic [3:0] bcnt_q, bcnt_d;
   logic       chime_q, chime_d;
   logic       lamp_q, lamp_d;
   logic       esc_q, esc_d;
   logic       timed;

   // Loss of the alarm always wins, then Ack, then timer expiry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (alarm_s_q) state_d = StQualify;
         end
         StQualify: begin
            if (!alarm_s_q) state_d = StIdle;
            else if (Tick && tcnt_q == DebLast) state_d = StBeepOn;
         end
         StBeepOn: begin
            if (!alarm_s_q) state_d = StIdle;
            else if (Ack) state_d = StSnooze;
            else if (Tick && tcnt_q == OnLast) state_d = StBeepOff;
         end
         StBeepOff: begin
            if (!alarm_s_q) state_d = StIdle;
            else if (Ack) state_d = StSnooze;
            else if (Tick && tcnt_q == OffLast) begin
               state_d = (bcnt_q == EscCnt) ? StEscalate : StBeepOn;
            end
         end
         StEscalate: begin
            if (!alarm_s_q) state_d = StIdle;
            else if (Ack) state_d = StSnooze;
         end
         StSnooze: begin
            if (!alarm_s_q) state_d = StIdle;
            else if (Tick && tcnt_q == SnzLast) state_d = StBeepOn;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      timed = (state_q == StQualify) || (state_q == StBeepOn) ||
              (state_q == StBeepOff) || (state_q == StSnooze);

      tcnt_d = tcnt_q;
      if (state_d != state_q) tcnt_d = '0;
      else if (timed && Tick) tcnt_d = tcnt_q + 8'd1;

      // A beep sequence starts from zero unless it is continuing from BEEP_OFF.
      bcnt_d = bcnt_q;
      if (state_d == StBeepOn && state_q != StBeepOn && state_q != StBeepOff) begin
         bcnt_d = '0;
      end else if (state_q == StBeepOn && state_d == StBeepOff) begin
         bcnt_d = bcnt_q + 4'd1;
      end

      chime_d = (state_d == StBeepOn) || (state_d == StEscalate);
      lamp_d  = (state_d == StBeepOn) || (state_d == StBeepOff) ||
                (state_d == StEscalate) || (state_d == StSnooze);
      esc_d   = (state_d == StEscalate);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         alarm_meta_q <= 1'b0;
         alarm_s_q    <= 1'b0;
         state_q      <= StIdle;
         tcnt_q       <= '0;
         bcnt_q       <= '0;
         chime_q      <= 1'b0;
         lamp_q       <= 1'b0;
         esc_q        <= 1'b0;
      end else begin
         alarm_meta_q <= Alarm;
         alarm_s_q    <= alarm_meta_q;
         state_q      <= state_d;
         tcnt_q       <= tcnt_d;
         bcnt_q       <= bcnt_d;
         chime_q      <= chime_d;
         lamp_q       <= lamp_d;
         esc_q        <= esc_d;
      end
   end

   assign Chime     = chime_q;
   assign Lamp      = lamp_q;
   assign Escalated = esc_q;
   assign State     = state_q;

endmodule

// File: tb/tb_car_alarm_chime.sv
// Scenario bench for car_alarm_chime: expected state/output timelines are queued
// from the scenario and popped one per clock as the DUT advances.
`timescale 1ns/1ps
module tb_car_alarm_chime;

   logic       Clk = 1'b0;
   logic       Rst, Alarm, Tick, Ack;
   logic       Chime, Lamp, Escalated;
   logic [2:0] State;

   localparam logic [2:0] SIdle = 3'd0, SQual = 3'd1, SOn = 3'd2;
   localparam logic [2:0] SOff = 3'd3, SEsc = 3'd4, SSnz = 3'd5;

   typedef struct packed {
      logic [2:0] st;
      logic       ch;
      logic       lp;
      logic       es;
   } exp_t;

   exp_t sb[$];
   int   exp_len[$];
   exp_t got, want;
   int   total = 0;
   int   bad = 0;

   car_alarm_chime dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Alarm     (Alarm),
      .Tick      (Tick),
      .Ack       (Ack),
      .Chime     (Chime),
      .Lamp      (Lamp),
      .Escalated (Escalated),
      .State     (State)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t decode(input logic [2:0] st);
      exp_t e;
      e.st = st;
      e.ch = (st == SOn) || (st == SEsc);
      e.lp = (st == SOn) || (st == SOff) || (st == SEsc) || (st == SSnz);
      e.es = (st == SEsc);
      return e;
   endfunction

   task automatic push(input logic [2:0] st, input int n);
      for (int i = 0; i < n; i++) sb.push_back(decode(st));
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] st, input int limit, output bit ok,
                             output int cycles);
      ok = 1'b0;
      cycles = 0;
      while (!ok && cycles < limit) begin
         step();
         cycles++;
         ok = (State == st);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1; Alarm = 1'b0; Tick = 1'b0; Ack = 1'b0;
      #3;
      got = {State, Chime, Lamp, Escalated};
      total++;
      if (got !== decode(SIdle)) begin
         bad++;
         $display("FAIL reset_async: got %b want %b (st,chime,lamp,esc)", got, decode(SIdle));
      end
      step(); step();
      got = {State, Chime, Lamp, Escalated};
      total++;
      if (got !== decode(SIdle)) begin
         bad++;
         $display("FAIL reset_held: got %b want %b (st,chime,lamp,esc)", got, decode(SIdle));
      end
      Rst = 1'b0;
      step(); step();
   endtask

   task automatic test_full_sequence();
      bit ok;
      int cyc, i;
      Tick = 1'b1;
      Alarm = 1'b1;
      wait_state(SQual, 10, ok, cyc);
      total++;
      if (!ok || cyc < 2 || cyc > 3) begin
         bad++;
         $display("FAIL qualify_entry: got ok=%0b after %0d clk want QUALIFY within 2..3", ok, cyc);
      end
      push(SQual, 3);
      for (int k = 0; k < 3; k++) begin
         push(SOn, 8);
         push(SOff, 8);
      end
      push(SEsc, 4);
      i = 0;
      while (sb.size() > 0) begin
         step();
         i++;
         want = sb.pop_front();
         got = {State, Chime, Lamp, Escalated};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL full_seq clk %0d: got %b want %b (st,chime,lamp,esc)", i, got, want);
         end
      end
   endtask

   // AlarmS drops on the same edge that samples Ack=1.
   task automatic test_escalate_clear();
      Alarm = 1'b0;
      push(SEsc, 2);
      push(SIdle, 3);
      for (int i = 1; i <= 5; i++) begin
         step();
         if (i == 2) Ack = 1'b1;
         if (i == 3) Ack = 1'b0;
         want = sb.pop_front();
         got = {State, Chime, Lamp, Escalated};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL esc_clear clk %0d: got %b want %b (st,chime,lamp,esc)", i, got, want);
         end
      end
   endtask

   task automatic test_short_alarm();
      Alarm = 1'b1;
      push(SIdle, 2);
      push(SQual, 4);
      push(SIdle, 4);
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 4) Alarm = 1'b0;
         want = sb.pop_front();
         got = {State, Chime, Lamp, Escalated};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL short_alarm clk %0d: got %b want %b (st,chime,lamp,esc)", i, got, want);
         end
      end
   endtask

   task automatic test_snooze();
      bit ok;
      int cyc, i;
      Tick = 1'b1;
      Alarm = 1'b1;
      wait_state(SOff, 40, ok, cyc);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL snooze_reach_off: got state %0d after %0d clk want 3", State, cyc);
      end
      Ack = 1'b1;
      push(SSnz, 64);
      for (int k = 0; k < 3; k++) begin
         push(SOn, 8);
         push(SOff, 8);
      end
      push(SEsc, 2);
      i = 0;
      while (sb.size() > 0) begin
         step();
         i++;
         if (i == 1 || i == 31) Ack = 1'b0;
         if (i == 30) Ack = 1'b1;
         want = sb.pop_front();
         got = {State, Chime, Lamp, Escalated};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL snooze clk %0d: got %b want %b (st,chime,lamp,esc)", i, got, want);
         end
      end
   endtask

   task automatic test_tick_gating();
      bit ok;
      int cyc, run;
      logic [2:0] prev;
      Alarm = 1'b0;
      Tick = 1'b1;
      wait_state(SIdle, 10, ok, cyc);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL gating_idle: got state %0d want 0", State);
      end
      step(); step();
      exp_len.push_back(32);
      exp_len.push_back(32);
      Tick = 1'b0;
      Alarm = 1'b1;
      cyc = 0;
      run = 0;
      prev = State;
      while (exp_len.size() > 0 && cyc < 300) begin
         step();
         cyc++;
         Tick = (cyc % 4 == 0);
         if (State == prev) begin
            run++;
         end else begin
            if (prev == SOn || prev == SOff) begin
               total++;
               if (run !== exp_len[0]) begin
                  bad++;
                  $display("FAIL phase_len st %0d: got %0d clk want %0d", prev, run, exp_len[0]);
               end
               void'(exp_len.pop_front());
            end
            prev = State;
            run = 1;
         end
      end
      total++;
      if (exp_len.size() != 0) begin
         bad++;
         $display("FAIL phase_timeout: got %0d phases left want 0", exp_len.size());
      end
      Tick = 1'b0;
      push(SOn, 40);
      for (int i = 1; sb.size() > 0; i++) begin
         step();
         want = sb.pop_front();
         got = {State, Chime, Lamp, Escalated};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL tick_freeze clk %0d: got %b want %b (st,chime,lamp,esc)", i, got, want);
         end
      end
   endtask

   task automatic test_async_reset();
      Tick = 1'b1;
      step();
      total++;
      if (State !== SOn) begin
         bad++;
         $display("FAIL pre_reset_state: got %0d want 2", State);
      end
      #2 Rst = 1'b1;
      #1 got = {State, Chime, Lamp, Escalated};
      total++;
      if (got !== decode(SIdle)) begin
         bad++;
         $display("FAIL async_reset: got %b want %b (st,chime,lamp,esc)", got, decode(SIdle));
      end
      #1 Rst = 1'b0;
      push(SIdle, 2);
      push(SQual, 4);
      push(SOn, 3);
      for (int i = 1; sb.size() > 0; i++) begin
         step();
         want = sb.pop_front();
         got = {State, Chime, Lamp, Escalated};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL post_reset clk %0d: got %b want %b (st,chime,lamp,esc)", i, got, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_escalate_clear();
      step(); step();
      test_short_alarm();
      test_snooze();
      test_tick_gating();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/car_alarm_chime.md
CAR_ALARM_CHIME -- requirements
Module: car_alarm_chime

Interface
REQ-001 Parameter DEB_TICKS, default 4: Tick strobes the synchronised Alarm must hold high before chiming; range 1..255.
REQ-002 Parameter ON_TICKS, default 8: Tick strobes per chime-on phase; range 1..255.
REQ-003 Parameter OFF_TICKS, default 8: Tick strobes per chime-off phase; range 1..255.
REQ-004 Parameter ESC_CYCLES, default 3: completed on/off beep cycles before escalation; range 1..15.
REQ-005 Parameter SNOOZE_TICKS, default 64: Tick strobes of silence after Ack; range 1..255.
REQ-006 Clk  input  1  single clock; all state changes on its rising edge.
REQ-007 Rst  input  1  reset, asynchronous, active-high.
REQ-008 Alarm  input  1  raw warning level from the upstream door/ignition/seat-belt logic; asynchronous to Clk.
REQ-009 Tick  input  1  one-Clk-wide timebase strobe; all timers advance only when Tick=1.
REQ-010 Ack  input  1  driver acknowledge, level sampled each Clk.
REQ-011 Chime  output  1  buzzer drive, registered.
REQ-012 Lamp  output  1  dashboard warning lamp, registered.
REQ-013 Escalated  output  1  continuous-tone indicator, registered.
REQ-014 State  output  3  current FSM state: IDLE=0, QUALIFY=1, BEEP_ON=2, BEEP_OFF=3, ESCALATE=4, SNOOZE=5.

Function
REQ-015 Alarm shall pass through a two-flop synchroniser (AlarmS); FSM uses AlarmS only; Alarm-to-AlarmS latency 2 Clk.
REQ-016 One 8-bit tick counter (TCnt) and one 4-bit beep counter (BCnt); TCnt cleared on every state change.
REQ-017 A phase of N ticks ends on the Clk edge where Tick=1 and TCnt=N-1; the transition takes effect at that edge.
REQ-018 IDLE: AlarmS=1 -> QUALIFY.
REQ-019 QUALIFY: AlarmS=0 -> IDLE; DEB_TICKS elapsed -> BEEP_ON with BCnt=0.
REQ-020 BEEP_ON: ON_TICKS elapsed -> BEEP_OFF, BCnt increments at this edge.
REQ-021 BEEP_OFF: OFF_TICKS elapsed -> ESCALATE if BCnt=ESC_CYCLES, else BEEP_ON.
REQ-022 ESCALATE: held until AlarmS=0 or Ack=1; no timer.
REQ-023 In BEEP_ON, BEEP_OFF, ESCALATE: AlarmS=0 -> IDLE; else Ack=1 -> SNOOZE; AlarmS=0 has priority over Ack and over timer expiry; Ack has priority over timer expiry.
REQ-024 SNOOZE: AlarmS=0 -> IDLE; SNOOZE_TICKS elapsed with AlarmS=1 -> BEEP_ON with BCnt=0; Ack while in SNOOZE ignored (no restart).
REQ-025 Ack in IDLE or QUALIFY ignored.
REQ-026 Outputs decoded from next state and registered: Chime=1 in BEEP_ON and ESCALATE; Lamp=1 in BEEP_ON, BEEP_OFF, ESCALATE, SNOOZE; Escalated=1 in ESCALATE only; State equals current state.
REQ-027 Tick=0 freezes all timers; Tick is ignored in IDLE and ESCALATE.
REQ-028 Unused State encodings 6,7 -> IDLE next Clk.

Reset
REQ-029 Rst=1 immediately (asynchronously) forces State=IDLE, TCnt=0, BCnt=0, synchroniser flops=0, Chime=0, Lamp=0, Escalated=0.
REQ-030 Rst asserted mid-beep or mid-snooze shall abandon the sequence; after release, a fresh QUALIFY is required before any chime.

Verification
REQ-031 Defaults, Tick every Clk, Alarm 0->1 held -> QUALIFY after 2 Clk, BEEP_ON/Chime=1 4 Clk later, Chime toggles every 8 Clk, ESCALATE with Escalated=1 after 3 full beep cycles.
REQ-032 Alarm high for 3 ticks then low -> never leaves QUALIFY/IDLE, Chime and Lamp stay 0.
REQ-033 In BEEP_OFF, Ack=1 for 1 Clk -> SNOOZE, Chime=0, Lamp=1; after 64 ticks with Alarm high -> BEEP_ON, BCnt=0.
REQ-034 In ESCALATE, Alarm and Ack fall/rise on same Clk (AlarmS=0, Ack=1) -> IDLE, not SNOOZE; all outputs 0.
REQ-035 Tick every 4th Clk -> each chime phase lasts 32 Clk; Tick=0 held in BEEP_ON -> Chime stays 1, State stays 2.
REQ-036 Rst pulsed asynchronously (between Clk edges) during BEEP_ON -> outputs 0 before next Clk edge; Alarm still high after release -> QUALIFY then BEEP_ON after 4 ticks.
